// File: rtl/reg_err_log_fifo_if.sv
// Log-beat capture and head-pop handshake between the error detector, the
// capture FIFO and its consumer (firmware or debug port).
interface reg_err_log_fifo_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic [2:0]        in_type;
  logic              in_err;
  logic              in_warn;
  logic              in_alert;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_type;
  logic [1:0]        out_sev;
  logic [15:0]       out_ts;

  // Drives log beats in and drains the head entry.
  modport master (
    output in_valid, in_addr, in_data, in_type, in_err, in_warn, in_alert,
    output out_ready,
    input  out_valid, out_addr, out_data, out_type, out_sev, out_ts
  );

  // The capture FIFO itself.
  modport slave (
    input  in_valid, in_addr, in_data, in_type, in_err, in_warn, in_alert,
    input  out_ready,
    output out_valid, out_addr, out_data, out_type, out_sev, out_ts
  );
endinterface

// File: rtl/reg_err_log_fifo.sv
// Timestamped capture FIFO for register-error log beats, with saturating
// overflow accounting and one sticky level interrupt.
module reg_err_log_fifo #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 8,
  parameter int IRQ_THRESH = 4,
  parameter bit LOG_ALL    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_err_log_fifo_if.slave      bus,
  input  logic                   irq_clr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic [15:0]            ovf_count,
  output logic                   ovf_flag,
  output logic                   irq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [2:0]        typ;
    logic [1:0]        sev;
    logic [15:0]       ts;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [15:0]       ts_ctr;
  logic              alert_sticky;

  logic              cap;
  logic              pop;
  logic              push;
  logic              drop;
  logic [CNT_W-1:0]  count_next;
  logic              alert_next;
  logic              ovf_next;

  // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    cap        = bus.in_valid & (LOG_ALL | (bus.in_type != 3'd0));
    pop        = ~empty & bus.out_ready;
    push       = cap & (~full | pop);
    drop       = cap & full & ~pop;
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    // A new set condition outranks a same-cycle clear.
    alert_next = (cap & bus.in_alert) | (alert_sticky & ~irq_clr);
    ovf_next   = drop | (ovf_flag & ~irq_clr);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      ts_ctr       <= '0;
      ovf_count    <= '0;
      ovf_flag     <= 1'b0;
      alert_sticky <= 1'b0;
      irq          <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count        <= count_next;
      full         <= (count_next == CNT_W'(DEPTH));
      empty        <= (count_next == '0);
      ts_ctr       <= ts_ctr + 16'd1;
      if (drop && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
      ovf_flag     <= ovf_next;
      alert_sticky <= alert_next;
      irq          <= (count_next >= CNT_W'(IRQ_THRESH)) | alert_next | ovf_next;
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= '{addr: bus.in_addr,
                       data: bus.in_data,
                       typ:  bus.in_type,
                       sev:  {bus.in_err, bus.in_warn},
                       ts:   ts_ctr};
    end
  end

  // First-word-fall-through head; fields are meaningless while empty.
  assign bus.out_valid = ~empty;
  assign bus.out_addr  = mem[rd_ptr].addr;
  assign bus.out_data  = mem[rd_ptr].data;
  assign bus.out_type  = mem[rd_ptr].typ;
  assign bus.out_sev   = mem[rd_ptr].sev;
  assign bus.out_ts    = mem[rd_ptr].ts;

endmodule
